ram_1p_arb: RTL and testbench
=============================

RAM_1P_ARB -- requirements
Module: ram_1p_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NumReq, 2, number of requesters (2..8).
- Width, 32, data and mask width.
- Aw, 9, address width.
- ReadLatency, 1, cycles from memory request to mem_rvalid_i (1..3).
REQ-002 The clock port SHALL be clk_i. The reset port SHALL be rst_ni. Reset is synchronous and active-low.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock.
- rst_ni, in, 1, synchronous active-low reset.
- req_i, in, NumReq, per-requester request.
- write_i, in, NumReq, per-requester write flag.
- addr_i, in, NumReq x Aw, address.
- wdata_i, in, NumReq x Width, write data.
- wmask_i, in, NumReq x Width, write mask.
- gnt_o, out, NumReq, one-hot grant.
- rvalid_o, out, NumReq, read response valid.
- rdata_o, out, Width, read data, shared by all requesters.
- rerror_o, out, 2, {uncorrectable, correctable}, shared.
- mem_req_o, out, 1, memory request.
- mem_write_o, out, 1, memory write flag.
- mem_addr_o, out, Aw, memory address.
- mem_wdata_o, out, Width, memory write data.
- mem_wmask_o, out, Width, memory write mask.
- mem_rvalid_i, in, 1, memory read response valid.
- mem_rdata_i, in, Width, memory read data.
- mem_rerror_i, in, 2, memory read error.
- err_o, out, 1, sticky protocol error.

Function
REQ-004 Grant SHALL be combinational in the request cycle: gnt_o[k]=1 SHALL drive mem_req_o=1 and mux requester k's write_i, addr_i, wdata_i and wmask_i onto the mem_* outputs in the same cycle.
REQ-005 At most one gnt_o bit SHALL be set per cycle, and only for a requester whose req_i is set. When no req_i is set, gnt_o=0 and mem_req_o=0.
REQ-006 Arbitration SHALL be round-robin. The search starts at index ptr_q. After any grant to k, ptr_q SHALL become (k+1) mod NumReq, so every requester is granted within NumReq cycles of asserting req_i.
REQ-007 A requester SHALL hold req_i and its payload stable until granted. Deasserting req_i without a grant is legal and SHALL be ignored.
REQ-008 Every granted read (write_i[k]=0) SHALL push index k into an in-order ID queue of depth ReadLatency+1. Writes SHALL push nothing.
REQ-009 When mem_rvalid_i=1, the block SHALL pop the queue head h and set rvalid_o[h]=1 combinationally. rdata_o SHALL equal mem_rdata_i, and rerror_o SHALL equal mem_rerror_i masked by mem_rvalid_i.
REQ-010 A push and a pop in the same cycle SHALL both take effect, and the occupancy count SHALL stay unchanged.
REQ-011 If mem_rvalid_i=1 while the queue is empty, the block SHALL set err_o=1 and assert no rvalid_o bit.
REQ-012 If the queue is full, the block SHALL grant no read. Writes SHALL still be granted.
REQ-013 err_o SHALL be sticky until reset.
REQ-014 Queue pointers SHALL wrap modulo the queue depth.

Reset
REQ-015 While rst_ni=0 at a clk_i edge: ptr_q=0, queue empty, err_o=0.
REQ-016 Output reset values: gnt_o=0 and mem_req_o=0 whenever rst_ni=0, regardless of req_i. rvalid_o=0 and rerror_o=0 whenever rst_ni=0.
REQ-017 When reset is applied mid-operation, responses to reads already issued SHALL be discarded, and a mem_rvalid_i arriving after reset SHALL set err_o.

Structure
REQ-018 A shared package ram_1p_arb_pkg SHALL hold the requester-index width function and the maximum-latency constant (3).
REQ-019 Round-robin selection SHALL live in one sub-module, ram_rr_arb. Its inputs are req and ptr. Its outputs are a one-hot gnt and an index.

Verification
REQ-020 Requests only from requester 1, ReadLatency=1 -> gnt_o=2'b10 in the same cycle, mem_addr_o=addr_i[1], rvalid_o=2'b10 one cycle later.
REQ-021 NumReq=2, both requesters hold req_i continuously for 6 cycles -> grants alternate 01,10,01,10,01,10.
REQ-022 ReadLatency=2, back-to-back reads from requester 0 then requester 1 -> rvalid_o=01 at cycle t+2, then 10 at cycle t+3, and rdata_o tracks mem_rdata_i.
REQ-023 mem_rvalid_i=1 with the queue empty -> err_o=1, which stays high until rst_ni=0.
REQ-024 Reset asserted one cycle after a read grant, ReadLatency=2 -> no rvalid_o is asserted afterwards, and err_o=1 when the stale mem_rvalid_i arrives.
REQ-025 A write granted while the queue is full -> mem_write_o=1 and the occupancy count is unchanged. A read under the same condition -> gnt_o=0.

Source files
------------

// File: rtl/ram_1p_arb_pkg.sv
// Shared constants and helpers for the single-port RAM arbiter.
package ram_1p_arb_pkg;

    localparam int unsigned MaxReadLatency = 3;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_rr_arb.sv
// Round-robin selector: picks the first set request at or after ptr, wrapping.
module ram_rr_arb
    import ram_1p_arb_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [IdxW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned i = NumReq; i > 0; i--) begin
            cand = IdxW'((32'(ptr_i) + i - 1) % NumReq);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/ram_1p_arb.sv
// Round-robin arbiter in front of a single-port RAM, routing read responses
// back to their requesters through an in-order ID queue.
module ram_1p_arb
    import ram_1p_arb_pkg::*;
#(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned Width       = 32,
    parameter int unsigned Aw          = 9,
    parameter int unsigned ReadLatency = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_i,
    input  logic [NumReq-1:0]            write_i,
    input  logic [NumReq-1:0][Aw-1:0]    addr_i,
    input  logic [NumReq-1:0][Width-1:0] wdata_i,
    input  logic [NumReq-1:0][Width-1:0] wmask_i,
    output logic [NumReq-1:0]            gnt_o,
    output logic [NumReq-1:0]            rvalid_o,
    output logic [Width-1:0]             rdata_o,
    output logic [1:0]                   rerror_o,
    output logic                         mem_req_o,
    output logic                         mem_write_o,
    output logic [Aw-1:0]                mem_addr_o,
    output logic [Width-1:0]             mem_wdata_o,
    output logic [Width-1:0]             mem_wmask_o,
    input  logic                         mem_rvalid_i,
    input  logic [Width-1:0]             mem_rdata_i,
    input  logic [1:0]                   mem_rerror_i,
    output logic                         err_o
);

    localparam int unsigned IdxW  = idx_width(NumReq);
    localparam int unsigned Depth = ReadLatency + 1;
    localparam int unsigned QpW   = idx_width(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);

    if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : gen_bad_latency
        $error("ram_1p_arb: ReadLatency out of range");
    end
    if (NumReq < 2 || NumReq > 8) begin : gen_bad_numreq
        $error("ram_1p_arb: NumReq out of range");
    end

    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] id_q [Depth];
    logic [QpW-1:0]  wr_q, rd_q;
    logic [CntW-1:0] cnt_q;
    logic            err_q;

    logic              q_full, q_empty, push, pop;
    logic [NumReq-1:0] eligible, arb_gnt;
    logic [IdxW-1:0]   arb_idx;

    assign q_full  = (cnt_q == CntW'(Depth));
    assign q_empty = (cnt_q == '0);

    // Reads are held off while the ID queue is full; writes never need a slot.
    assign eligible = rst_ni ? (req_i & (write_i | {NumReq{~q_full}})) : '0;

    ram_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_arb (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign gnt_o       = arb_gnt;
    assign mem_req_o   = |arb_gnt;
    assign mem_write_o = write_i[arb_idx];
    assign mem_addr_o  = addr_i[arb_idx];
    assign mem_wdata_o = wdata_i[arb_idx];
    assign mem_wmask_o = wmask_i[arb_idx];

    assign push = mem_req_o & ~mem_write_o;
    assign pop  = rst_ni & mem_rvalid_i & ~q_empty;

    always_comb begin
        rvalid_o = '0;
        if (pop) begin
            rvalid_o[id_q[rd_q]] = 1'b1;
        end
    end

    assign rdata_o  = mem_rdata_i;
    assign rerror_o = (rst_ni && mem_rvalid_i) ? mem_rerror_i : 2'b00;
    assign err_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (mem_req_o) begin
                ptr_q <= (arb_idx == IdxW'(NumReq - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (push) begin
                wr_q <= (wr_q == QpW'(Depth - 1)) ? '0 : wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= (rd_q == QpW'(Depth - 1)) ? '0 : rd_q + 1'b1;
            end
            if (push != pop) begin
                cnt_q <= push ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
            if (mem_rvalid_i && q_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_q] <= arb_idx;
        end
    end

endmodule

// File: tb/tb_ram_1p_arb.sv
// Scoreboard bench for ram_1p_arb: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them, and a small memory model answers reads.
module tb_ram_1p_arb;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [1:0]      req_i, write_i;
    logic [1:0][8:0] addr_i;
    logic [1:0][31:0] wdata_i, wmask_i;
    logic [1:0]      gnt_o, rvalid_o, rerror_o;
    logic [31:0]     rdata_o;
    logic            mem_req_o, mem_write_o, err_o;
    logic [8:0]      mem_addr_o;
    logic [31:0]     mem_wdata_o, mem_wmask_o;
    logic            mem_rvalid_i;
    logic [31:0]     mem_rdata_i;
    logic [1:0]      mem_rerror_i;

    ram_1p_arb #(
        .NumReq      (2),
        .Width       (32),
        .Aw          (9),
        .ReadLatency (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .write_i      (write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .wmask_i      (wmask_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rerror_o     (rerror_o),
        .mem_req_o    (mem_req_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rerror_i (mem_rerror_i),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  gnt;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        int          cyc;
    } gnt_t;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] data;
        logic [1:0]  rerr;
        int          cyc;
    } rsp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  rerr;
    } mem_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    mem_t mem_q[$];
    gnt_t mon_g;
    rsp_t mon_r;

    int cyc = 0;
    int mem_lat = 1;
    int inject_at = -1;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_g(input logic [1:0] g, input logic w, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] wm);
        exp_gnt.push_back('{g, w, a, wd, wm, cyc});
    endtask

    task automatic exp_r(input logic [1:0] rv, input logic [31:0] d, input logic [1:0] e,
                         input int lat);
        exp_rsp.push_back('{rv, d, e, cyc + lat});
    endtask

    // Memory model: answers each read mem_lat cycles after its grant; inject_at forces a stray beat.
    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hBAD0_BAD0;
        mem_rerror_i = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hBAD0_BAD0;
            mem_rerror_i = 2'b11;
            if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_q[0].data;
                mem_rerror_i = mem_q[0].rerr;
                void'(mem_q.pop_front());
            end else if (cyc == inject_at) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'h0BAD_F00D;
                mem_rerror_i = 2'b10;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst_ni) begin
            check("rst_gnt", 32'(gnt_o), 32'd0);
            check("rst_mem_req", 32'(mem_req_o), 32'd0);
            check("rst_rvalid", 32'(rvalid_o), 32'd0);
            check("rst_rerror", 32'(rerror_o), 32'd0);
        end else begin
            if (mem_req_o) begin
                if (exp_gnt.size() == 0) begin
                    flag("unexpected_grant");
                end else begin
                    mon_g = exp_gnt.pop_front();
                    check("gnt", 32'(gnt_o), 32'(mon_g.gnt));
                    check("gnt_cycle", 32'(cyc), 32'(mon_g.cyc));
                    check("mem_write", 32'(mem_write_o), 32'(mon_g.wr));
                    check("mem_addr", 32'(mem_addr_o), 32'(mon_g.addr));
                    if (mon_g.wr) begin
                        check("mem_wdata", mem_wdata_o, mon_g.wdata);
                        check("mem_wmask", mem_wmask_o, mon_g.wmask);
                    end
                end
                if (!mem_write_o) begin
                    mem_q.push_back('{cyc + mem_lat, 32'hA500_0000 | 32'(mem_addr_o),
                                      mem_addr_o[1:0]});
                end
            end else if (gnt_o != 2'b00) begin
                check("gnt_without_mem_req", 32'(gnt_o), 32'd0);
            end
            while (exp_rsp.size() > 0 && exp_rsp[0].cyc < cyc) begin
                flag("missing_rvalid");
                void'(exp_rsp.pop_front());
            end
            if (rvalid_o != 2'b00) begin
                if (exp_rsp.size() == 0) begin
                    flag("unexpected_rvalid");
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rvalid", 32'(rvalid_o), 32'(mon_r.rv));
                    check("rvalid_cycle", 32'(cyc), 32'(mon_r.cyc));
                    check("rdata", rdata_o, mon_r.data);
                    check("rerror", 32'(rerror_o), 32'(mon_r.rerr));
                end
            end
            if (!mem_rvalid_i) begin
                check("rerror_masked", 32'(rerror_o), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni     = 1'b0;
        req_i      = 2'b11;
        write_i    = 2'b00;
        addr_i[0]  = 9'h0AA;
        addr_i[1]  = 9'h055;
        wdata_i[0] = 32'h1234_5678;
        wdata_i[1] = 32'hDEAD_BEEF;
        wmask_i[0] = 32'h0000_FFFF;
        wmask_i[1] = 32'hFFFF_0000;
        inject_at  = 2;  // stray beat during reset must be ignored
        repeat (3) step();
        rst_ni = 1'b1;
        req_i  = 2'b00;
        step();
        @(negedge clk);
        check("err_after_reset", 32'(err_o), 32'd0);

        // Single read from requester 1, one-cycle memory.
        mem_lat = 1;
        step();
        req_i = 2'b10;
        exp_g(2'b10, 1'b0, 9'h055, 32'd0, 32'd0);
        exp_r(2'b10, 32'hA500_0055, 2'b01, 1);
        step();
        req_i = 2'b00;
        repeat (3) step();

        // Both requesters hold reads for six cycles: grants alternate.
        addr_i[0] = 9'h010;
        addr_i[1] = 9'h021;
        req_i     = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                exp_g(2'b01, 1'b0, 9'h010, 32'd0, 32'd0);
                exp_r(2'b01, 32'hA500_0010, 2'b00, 1);
            end else begin
                exp_g(2'b10, 1'b0, 9'h021, 32'd0, 32'd0);
                exp_r(2'b10, 32'hA500_0021, 2'b01, 1);
            end
            step();
        end
        req_i = 2'b00;
        repeat (3) step();

        // Back-to-back reads with two-cycle memory.
        mem_lat   = 2;
        addr_i[0] = 9'h100;
        addr_i[1] = 9'h1F3;
        req_i     = 2'b01;
        exp_g(2'b01, 1'b0, 9'h100, 32'd0, 32'd0);
        exp_r(2'b01, 32'hA500_0100, 2'b00, 2);
        step();
        req_i = 2'b10;
        exp_g(2'b10, 1'b0, 9'h1F3, 32'd0, 32'd0);
        exp_r(2'b10, 32'hA500_01F3, 2'b11, 2);
        step();
        req_i = 2'b00;
        repeat (4) step();

        // Fill the three-entry ID queue with slow reads.
        mem_lat = 20;
        req_i   = 2'b01;
        addr_i[0] = 9'h030;
        exp_g(2'b01, 1'b0, 9'h030, 32'd0, 32'd0);
        exp_r(2'b01, 32'hA500_0030, 2'b00, 20);
        step();
        addr_i[0] = 9'h031;
        exp_g(2'b01, 1'b0, 9'h031, 32'd0, 32'd0);
        exp_r(2'b01, 32'hA500_0031, 2'b01, 20);
        step();
        addr_i[0] = 9'h032;
        exp_g(2'b01, 1'b0, 9'h032, 32'd0, 32'd0);
        exp_r(2'b01, 32'hA500_0032, 2'b10, 20);
        step();
        // Queue full: write from requester 1 still wins, read from 0 waits.
        addr_i[0] = 9'h033;
        addr_i[1] = 9'h1C0;
        req_i     = 2'b11;
        write_i   = 2'b10;
        exp_g(2'b10, 1'b1, 9'h1C0, 32'hDEAD_BEEF, 32'hFFFF_0000);
        @(negedge clk);
        check("full_write_gnt", 32'(gnt_o), 32'h2);
        check("full_mem_write", 32'(mem_write_o), 32'd1);
        step();
        req_i   = 2'b01;
        write_i = 2'b00;
        @(negedge clk);
        check("full_read_gnt", 32'(gnt_o), 32'd0);
        check("full_read_mem_req", 32'(mem_req_o), 32'd0);
        step();
        req_i = 2'b00;
        repeat (22) step();

        // Stray response on an empty queue: sticky error.
        inject_at = cyc + 1;
        step();
        step();
        @(negedge clk);
        check("err_set", 32'(err_o), 32'd1);
        repeat (3) step();
        @(negedge clk);
        check("err_sticky", 32'(err_o), 32'd1);
        step();
        rst_ni = 1'b0;
        step();
        @(negedge clk);
        check("err_cleared", 32'(err_o), 32'd0);
        step();
        rst_ni = 1'b1;
        step();

        // Reset one cycle after a read grant: the late response is stale.
        mem_lat   = 2;
        addr_i[0] = 9'h044;
        req_i     = 2'b01;
        exp_g(2'b01, 1'b0, 9'h044, 32'd0, 32'd0);
        step();
        req_i  = 2'b00;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        @(negedge clk);
        check("stale_err", 32'(err_o), 32'd1);
        repeat (3) step();

        @(negedge clk);
        check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
